multi_bank_buf: RTL and testbench

MULTI_BANK_BUF -- requirements
Module: multi_bank_buf

---
 rtl/multi_bank_buf.sv | 96 +++++++++
 tb/tb_multi_bank_buf.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_bank_buf.sv
// Ring of NUM_BANKS frame buffers: one writer fills and commits banks in order,
// many parallel read ports read the oldest committed bank until it is released.
module multi_bank_buf #(
   parameter int NUM_BANKS    = 3,
   parameter int DEPTH        = 1000,
   parameter int WIDTH        = 16,
   parameter int ADDR_WIDTH   = 16,
   parameter int OUT_PORT_NUM = 25
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             wr_en,
   input  logic [ADDR_WIDTH-1:0]            wr_addr,
   input  logic [WIDTH-1:0]                 wr_data,
   input  logic                             wr_done,
   input  logic [OUT_PORT_NUM*ADDR_WIDTH-1:0] rd_addr_NP,
   output logic [OUT_PORT_NUM*WIDTH-1:0]    rd_data_NP,
   input  logic                             rd_done,
   output logic [3:0]                       fill_cnt,
   output logic                             full,
   output logic                             empty,
   output logic [2:0]                       wr_bank,
   output logic [2:0]                       rd_bank,
   output logic                             wr_err,
   output logic                             rd_err
);

   localparam int BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam int IDX_BITS  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [3:0] FULL_CNT  = 4'(NUM_BANKS);
   localparam logic [2:0] LAST_BANK = 3'(NUM_BANKS - 1);

   logic [WIDTH-1:0] mem [NUM_BANKS][DEPTH];

   logic wr_in_range;
   logic wr_ok;
   logic wr_commit;
   logic rd_release;

   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
      return ({1'b0, addr} < DEPTH_LIM);
   endfunction

   function automatic logic [2:0] next_bank(input logic [2:0] bank);
      return (bank == LAST_BANK) ? 3'd0 : bank + 3'd1;
   endfunction

   assign full        = (fill_cnt == FULL_CNT);
   assign empty       = (fill_cnt == 4'd0);
   assign wr_in_range = in_range(wr_addr);
   assign wr_ok       = wr_en && !full && wr_in_range;
   assign wr_commit   = wr_done && !full;
   assign rd_release  = rd_done && !empty;

   // A release and a commit in the same cycle cancel out in the fill count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill_cnt <= 4'd0;
         wr_bank  <= 3'd0;
         rd_bank  <= 3'd0;
         wr_err   <= 1'b0;
         rd_err   <= 1'b0;
      end else begin
         if (wr_commit) wr_bank <= next_bank(wr_bank);
         if (rd_release) rd_bank <= next_bank(rd_bank);
         case ({wr_commit, rd_release})
            2'b10:   fill_cnt <= fill_cnt + 4'd1;
            2'b01:   fill_cnt <= fill_cnt - 4'd1;
            default: fill_cnt <= fill_cnt;
         endcase
         wr_err <= (wr_en && (full || !wr_in_range)) || (wr_done && full);
         rd_err <= rd_done && empty;
      end
   end

   // Storage keeps its contents across reset; only the ring bookkeeping is cleared.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_bank[BANK_BITS-1:0]][wr_addr[IDX_BITS-1:0]] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_NP <= '0;
      end else begin
         for (int k = 0; k < OUT_PORT_NUM; k++) begin
            if (in_range(rd_addr_NP[k*ADDR_WIDTH +: ADDR_WIDTH]))
               rd_data_NP[k*WIDTH +: WIDTH] <=
                  mem[rd_bank[BANK_BITS-1:0]][rd_addr_NP[k*ADDR_WIDTH +: IDX_BITS]];
            else
               rd_data_NP[k*WIDTH +: WIDTH] <= '0;
         end
      end
   end

endmodule

// File: tb/tb_multi_bank_buf.sv
// Self-checking bench for multi_bank_buf: ring-buffer model compared every cycle,
// plus hand-computed directed checks for reset, wrap, full/empty and error cases.
module tb_multi_bank_buf;

   localparam int NB = 3;
   localparam int DP = 16;
   localparam int W  = 16;
   localparam int AW = 16;
   localparam int NP = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic [W-1:0]      wr_data;
   logic              wr_done;
   logic [NP*AW-1:0]  rd_addr_NP;
   logic [NP*W-1:0]   rd_data_NP;
   logic              rd_done;
   logic [3:0]        fill_cnt;
   logic              full;
   logic              empty;
   logic [2:0]        wr_bank;
   logic [2:0]        rd_bank;
   logic              wr_err;
   logic              rd_err;

   int n_cmp = 0;
   int n_bad = 0;
   bit checking = 1'b0;

   multi_bank_buf #(
      .NUM_BANKS(NB), .DEPTH(DP), .WIDTH(W), .ADDR_WIDTH(AW), .OUT_PORT_NUM(NP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_done(wr_done), .rd_addr_NP(rd_addr_NP), .rd_data_NP(rd_data_NP),
      .rd_done(rd_done), .fill_cnt(fill_cnt), .full(full), .empty(empty),
      .wr_bank(wr_bank), .rd_bank(rd_bank), .wr_err(wr_err), .rd_err(rd_err)
   );

   always #5 clk = ~clk;

   // Reference ring: bank contents, which words were ever written, and bookkeeping.
   logic [W-1:0] m_mem [NB][DP];
   bit           m_known [NB][DP];
   int           m_cnt = 0;
   int           m_wp = 0;
   int           m_rp = 0;
   bit           m_werr = 1'b0;
   bit           m_rerr = 1'b0;
   logic [W-1:0] m_rd [NP] = '{default: '0};
   bit           m_rd_known [NP] = '{default: 1'b1};

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt  <= 0;
         m_wp   <= 0;
         m_rp   <= 0;
         m_werr <= 1'b0;
         m_rerr <= 1'b0;
         for (int k = 0; k < NP; k++) begin
            m_rd[k]       <= '0;
            m_rd_known[k] <= 1'b1;
         end
      end else begin
         for (int k = 0; k < NP; k++) begin
            if (int'(rd_addr_NP[k*AW +: AW]) < DP) begin
               m_rd[k]       <= m_mem[m_rp][int'(rd_addr_NP[k*AW +: AW])];
               m_rd_known[k] <= m_known[m_rp][int'(rd_addr_NP[k*AW +: AW])];
            end else begin
               m_rd[k]       <= '0;
               m_rd_known[k] <= 1'b1;
            end
         end
         m_werr <= (wr_en && (m_cnt == NB || int'(wr_addr) >= DP)) || (wr_done && m_cnt == NB);
         m_rerr <= rd_done && (m_cnt == 0);
         if (wr_en && m_cnt < NB && int'(wr_addr) < DP) begin
            m_mem[m_wp][int'(wr_addr)]   <= wr_data;
            m_known[m_wp][int'(wr_addr)] <= 1'b1;
         end
         if (wr_done && m_cnt < NB) m_wp <= (m_wp + 1) % NB;
         if (rd_done && m_cnt > 0)  m_rp <= (m_rp + 1) % NB;
         m_cnt <= m_cnt + ((wr_done && m_cnt < NB) ? 1 : 0) - ((rd_done && m_cnt > 0) ? 1 : 0);
      end
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_bad = n_bad + 1;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (checking && rst_n) begin
         check_output("fill_cnt", 32'(fill_cnt), 32'(m_cnt));
         check_output("full", 32'(full), 32'(m_cnt == NB));
         check_output("empty", 32'(empty), 32'(m_cnt == 0));
         check_output("wr_bank", 32'(wr_bank), 32'(m_wp));
         check_output("rd_bank", 32'(rd_bank), 32'(m_rp));
         check_output("wr_err", 32'(wr_err), 32'(m_werr));
         check_output("rd_err", 32'(rd_err), 32'(m_rerr));
         for (int k = 0; k < NP; k++)
            if (m_rd_known[k])
               check_output("rd_data", 32'(rd_data_NP[k*W +: W]), 32'(m_rd[k]));
      end
   end

   // Drives one cycle's inputs at a falling edge and returns at the next falling edge.
   task automatic apply_stimulus(input bit we, input int wa, input int wd, input bit wdn,
                                 input bit rdn, input int a0, input int a1);
      wr_en      = we;
      wr_addr    = AW'(wa);
      wr_data    = W'(wd);
      wr_done    = wdn;
      rd_done    = rdn;
      rd_addr_NP = {AW'(a1), AW'(a0)};
      @(negedge clk);
   endtask

   task automatic check_reset_values(input string tag);
      check_output({tag, "_fill"}, 32'(fill_cnt), 32'd0);
      check_output({tag, "_empty"}, 32'(empty), 32'd1);
      check_output({tag, "_full"}, 32'(full), 32'd0);
      check_output({tag, "_wr_bank"}, 32'(wr_bank), 32'd0);
      check_output({tag, "_rd_bank"}, 32'(rd_bank), 32'd0);
      check_output({tag, "_wr_err"}, 32'(wr_err), 32'd0);
      check_output({tag, "_rd_err"}, 32'(rd_err), 32'd0);
      check_output({tag, "_rd_data"}, rd_data_NP, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_done = 1'b0; rd_done = 1'b0;
      rd_addr_NP = '0;
      #12;
      check_reset_values("por");
      @(negedge clk);
      rst_n = 1'b1;
      checking = 1'b1;

      // Release with nothing committed, then an out-of-range write.
      apply_stimulus(0, 0, 0, 0, 1, 0, 0);
      check_output("rd_err_empty", 32'(rd_err), 32'd1);
      check_output("rd_bank_empty", 32'(rd_bank), 32'd0);
      check_output("fill_empty", 32'(fill_cnt), 32'd0);
      apply_stimulus(1, 20, 16'hBEEF, 0, 0, 0, 0);
      check_output("wr_err_range", 32'(wr_err), 32'd1);
      apply_stimulus(0, 0, 0, 0, 0, 0, 0);
      check_output("wr_err_pulse", 32'(wr_err), 32'd0);

      // Fill bank0; the last write coincides with its commit.
      for (int a = 0; a < DP; a++) apply_stimulus(1, a, 16'h100 + a, a == DP - 1, 0, 0, 0);
      check_output("fill_one", 32'(fill_cnt), 32'd1);
      check_output("wr_bank_one", 32'(wr_bank), 32'd1);
      apply_stimulus(0, 0, 0, 0, 0, 3, 15);
      check_output("rd_bank0", rd_data_NP, 32'h010F_0103);
      check_output("rd_bank_idx", 32'(rd_bank), 32'd0);

      for (int a = 0; a < DP; a++) apply_stimulus(1, a, 16'h200 + a, a == DP - 1, 0, 0, 0);
      for (int a = 0; a < DP; a++) apply_stimulus(1, a, 16'h300 + a, a == DP - 1, 0, 0, 0);
      check_output("fill_full", 32'(fill_cnt), 32'd3);
      check_output("full_flag", 32'(full), 32'd1);
      check_output("wr_bank_wrap", 32'(wr_bank), 32'd0);
      apply_stimulus(0, 0, 0, 1, 0, 0, 0);
      check_output("wr_err_full_done", 32'(wr_err), 32'd1);
      check_output("fill_stays", 32'(fill_cnt), 32'd3);
      apply_stimulus(1, 3, 16'hDEAD, 0, 0, 0, 0);
      check_output("wr_err_full_write", 32'(wr_err), 32'd1);
      apply_stimulus(0, 0, 0, 0, 0, 3, 15);
      check_output("bank0_intact", rd_data_NP, 32'h010F_0103);

      apply_stimulus(0, 0, 0, 0, 1, 0, 0);
      apply_stimulus(0, 0, 0, 0, 1, 0, 0);
      check_output("fill_after_rel", 32'(fill_cnt), 32'd1);
      check_output("rd_bank_two", 32'(rd_bank), 32'd2);
      for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 0, 1, 1, 0, 0);
      check_output("fill_simul", 32'(fill_cnt), 32'd1);
      check_output("wr_bank_simul", 32'(wr_bank), 32'd1);
      check_output("rd_bank_simul", 32'(rd_bank), 32'd0);

      // Both pulses while full: only the release lands.
      apply_stimulus(0, 0, 0, 1, 0, 0, 0);
      apply_stimulus(0, 0, 0, 1, 0, 0, 0);
      apply_stimulus(0, 0, 0, 1, 1, 0, 0);
      check_output("fill_full_both", 32'(fill_cnt), 32'd2);
      check_output("wr_err_full_both", 32'(wr_err), 32'd1);
      check_output("wr_bank_full_both", 32'(wr_bank), 32'd0);
      check_output("rd_bank_full_both", 32'(rd_bank), 32'd1);
      apply_stimulus(1, 20, 0, 0, 0, 31, 0);
      check_output("rd_addr_31", rd_data_NP, 32'h0200_0000);

      // Asynchronous reset in the middle of a write cycle.
      wr_en = 1'b1; wr_addr = 16'd7; wr_data = 16'h0777;
      #3 rst_n = 1'b0;
      #1 check_reset_values("async");
      wr_en = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      apply_stimulus(1, 5, 16'h0555, 1, 0, 0, 0);
      check_output("refill_cnt", 32'(fill_cnt), 32'd1);
      check_output("refill_wr_bank", 32'(wr_bank), 32'd1);
      apply_stimulus(0, 0, 0, 0, 0, 5, 3);
      check_output("refill_data", rd_data_NP, 32'h0103_0555);

      for (int i = 0; i < 10000; i++) begin
         apply_stimulus($urandom_range(0, 1) == 1, $urandom_range(0, 19), $urandom_range(0, 65535),
                        $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                        ($urandom_range(0, 9) == 0) ? 31 : $urandom_range(0, 17),
                        $urandom_range(0, 17));
      end

      checking = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
